// File: rtl/pi1r.sv
// pi1r: multi-master to single-slave PI1 arbiter with request FIFO and per-master completion
module pi1r #(
  parameter int MASTERCOUNT = 2,
  parameter int ARCHBITSZ = 32,
  parameter int DEPTH = 2,
  parameter int ARBMODE = 0,
  localparam int SELW = ARCHBITSZ / 8,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [2*MASTERCOUNT-1:0]         m_op_i_flat,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i_flat,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i_flat,
  input  logic [SELW*MASTERCOUNT-1:0]      m_sel_i_flat,
  output logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_o_flat,
  output logic [MASTERCOUNT-1:0]           m_rdy_o_flat,
  output logic [1:0]                       s_op_o,
  output logic [ADDRBITSZ-1:0]             s_addr_o,
  output logic [ARCHBITSZ-1:0]             s_data_o,
  output logic [SELW-1:0]                  s_sel_o,
  input  logic [ARCHBITSZ-1:0]             s_data_i,
  input  logic                             s_rdy_i
);
  localparam int IW = MASTERCOUNT > 1 ? $clog2(MASTERCOUNT) : 1;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [IW-1:0]        f_idx  [DEPTH];
  logic [1:0]           f_op   [DEPTH];
  logic [ADDRBITSZ-1:0] f_addr [DEPTH];
  logic [ARCHBITSZ-1:0] f_data [DEPTH];
  logic [SELW-1:0]      f_sel  [DEPTH];
  logic [PW-1:0]        rp, wp;
  logic [CW-1:0]        count;
  logic [MASTERCOUNT-1:0] pending, elig;
  logic [IW-1:0]        rrptr, gnt, inf_idx;
  logic                 inf_v, full, empty, pop, push, comp;
  assign full   = count == CW'(DEPTH);
  assign empty  = count == '0;
  assign pop    = s_rdy_i && !empty;
  assign push   = |elig && (!full || pop);
  assign comp   = inf_v && s_rdy_i;
  assign s_op_o   = empty ? 2'b00 : f_op[rp];
  assign s_addr_o = f_addr[rp];
  assign s_data_o = f_data[rp];
  assign s_sel_o  = f_sel[rp];
  // a master may be granted only while it has an op, nothing outstanding and no completion pulse showing
  always_comb begin
    elig = '0;
    for (int i = 0; i < MASTERCOUNT; i++)
      elig[i] = m_op_i_flat[2*i +: 2] != 2'b00 && !pending[i] && !m_rdy_o_flat[i];
  end
  // scan downwards so the candidate closest to the search start is the one kept
  always_comb begin
    gnt = '0;
    for (int k = MASTERCOUNT - 1; k >= 0; k--) begin
      int j;
      j = ARBMODE != 0 ? k : (int'(rrptr) + k) % MASTERCOUNT;
      if (elig[j]) gnt = IW'(j);
    end
  end
  // request storage needs no reset; only the pointers and count decide validity
  always_ff @(posedge clk_i) begin
    if (push) begin
      f_idx[wp]  <= gnt;
      f_op[wp]   <= m_op_i_flat[2*gnt +: 2];
      f_addr[wp] <= m_addr_i_flat[ADDRBITSZ*gnt +: ADDRBITSZ];
      f_data[wp] <= m_data_i_flat[ARCHBITSZ*gnt +: ARCHBITSZ];
      f_sel[wp]  <= m_sel_i_flat[SELW*gnt +: SELW];
    end
  end
  // pointers, arbitration state, inflight tracking and registered master responses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      pending <= '0;
      rrptr <= '0;
      inf_v <= 1'b0;
      inf_idx <= '0;
      m_rdy_o_flat <= '0;
      m_data_o_flat <= '0;
    end else begin
      m_rdy_o_flat <= '0;
      count <= count + CW'(push) - CW'(pop);
      inf_v <= pop || (inf_v && !s_rdy_i);
      if (push) begin
        wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
        pending[gnt] <= 1'b1;
        rrptr <= gnt == IW'(MASTERCOUNT - 1) ? '0 : gnt + 1'b1;
      end
      if (pop) begin
        rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
        inf_idx <= f_idx[rp];
      end
      if (comp) begin
        m_rdy_o_flat[inf_idx] <= 1'b1;
        m_data_o_flat[ARCHBITSZ*inf_idx +: ARCHBITSZ] <= s_data_i;
        pending[inf_idx] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pi1r.sv
// tb_pi1r: directed bench for pi1r with a round-robin and a fixed-priority instance
module tb_pi1r;
  localparam int MC = 4;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int SW = 4;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_rdy = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [2*MC-1:0] m_op = '0;
  logic [AW*MC-1:0] m_addr = '0;
  logic [DW*MC-1:0] m_wdata = '0;
  logic [SW*MC-1:0] m_sel = '0;
  logic [DW*MC-1:0] rr_data, fp_data;
  logic [MC-1:0] rr_rdy, fp_rdy;
  logic [1:0] rr_sop, fp_sop;
  logic [AW-1:0] rr_saddr, fp_saddr;
  logic [DW-1:0] rr_sdata, fp_sdata;
  logic [SW-1:0] rr_ssel, fp_ssel;
  int checks = 0;
  int errors = 0;
  int rr_q[$], rr_c[$], fp_q[$], fp_c[$];

  pi1r #(.MASTERCOUNT(MC), .ARCHBITSZ(DW), .DEPTH(DEPTH), .ARBMODE(0)) u_rr (
    .clk_i(clk), .rst_i(rst), .m_op_i_flat(m_op), .m_addr_i_flat(m_addr),
    .m_data_i_flat(m_wdata), .m_sel_i_flat(m_sel), .m_data_o_flat(rr_data),
    .m_rdy_o_flat(rr_rdy), .s_op_o(rr_sop), .s_addr_o(rr_saddr), .s_data_o(rr_sdata),
    .s_sel_o(rr_ssel), .s_data_i(s_data), .s_rdy_i(s_rdy));

  pi1r #(.MASTERCOUNT(MC), .ARCHBITSZ(DW), .DEPTH(DEPTH), .ARBMODE(1)) u_fp (
    .clk_i(clk), .rst_i(rst), .m_op_i_flat(m_op), .m_addr_i_flat(m_addr),
    .m_data_i_flat(m_wdata), .m_sel_i_flat(m_sel), .m_data_o_flat(fp_data),
    .m_rdy_o_flat(fp_rdy), .s_op_o(fp_sop), .s_addr_o(fp_saddr), .s_data_o(fp_sdata),
    .s_sel_o(fp_ssel), .s_data_i(s_data), .s_rdy_i(s_rdy));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    m_op = '0;
    s_rdy = 1'b0;
    s_data = '0;
    m_sel = '1;
    for (int i = 0; i < MC; i++) begin
      m_addr[AW*i +: AW] = AW'(i);
      m_wdata[DW*i +: DW] = 32'h1000 + i;
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic collect(input int n);
    rr_q.delete(); rr_c.delete(); fp_q.delete(); fp_c.delete();
    for (int c = 0; c < 60 && (rr_q.size() < n || fp_q.size() < n); c++) begin
      if (s_rdy && rr_sop != 2'b00 && rr_q.size() < n) begin
        rr_q.push_back(int'(rr_saddr));
        rr_c.push_back(c);
      end
      if (s_rdy && fp_sop != 2'b00 && fp_q.size() < n) begin
        fp_q.push_back(int'(fp_saddr));
        fp_c.push_back(c);
      end
      tick();
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (rr_sop !== 2'b00) begin errors++; $display("FAIL reset_sop: got %b expected 00", rr_sop); end
    checks++; if (fp_sop !== 2'b00) begin errors++; $display("FAIL reset_fp_sop: got %b expected 00", fp_sop); end
    checks++; if (rr_rdy !== '0) begin errors++; $display("FAIL reset_rdy: got %b expected 0000", rr_rdy); end
    checks++; if (rr_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", rr_data); end
  endtask

  task automatic test_single_read;
    do_reset();
    m_addr[AW-1:0] = 30'h10;
    s_data = 32'hDEADBEEF;
    s_rdy = 1'b1;
    m_op[1:0] = 2'b10;
    checks++; if (rr_sop !== 2'b00) begin errors++; $display("FAIL rd_c0_sop: got %b expected 00", rr_sop); end
    tick();
    checks++; if (rr_sop !== 2'b10) begin errors++; $display("FAIL rd_c1_sop: got %b expected 10", rr_sop); end
    checks++; if (rr_saddr !== 30'h10) begin errors++; $display("FAIL rd_c1_addr: got %h expected 10", rr_saddr); end
    tick();
    checks++; if (rr_rdy !== 4'b0000) begin errors++; $display("FAIL rd_c2_rdy: got %b expected 0000", rr_rdy); end
    tick();
    checks++; if (rr_rdy !== 4'b0001) begin errors++; $display("FAIL rd_c3_rdy: got %b expected 0001", rr_rdy); end
    checks++; if (rr_data[DW-1:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rr_data[DW-1:0]); end
    m_op = '0;
    tick();
    checks++; if (rr_rdy !== 4'b0000) begin errors++; $display("FAIL rd_c4_rdy: got %b expected 0000", rr_rdy); end
  endtask

  task automatic test_round_robin;
    do_reset();
    s_rdy = 1'b1;
    m_op = 8'b01010101;
    collect(8);
    checks++;
    if (rr_q.size() != 8) begin
      errors++; $display("FAIL rr_count: got %0d accepts expected 8", rr_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++; if (rr_q[k] != k % 4) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, rr_q[k], k % 4); end
        checks++; if (rr_c[k] != k + 1) begin errors++; $display("FAIL rr_cycle[%0d]: got %0d expected %0d", k, rr_c[k], k + 1); end
      end
    end
    m_op = '0;
  endtask

  task automatic test_fixed_priority;
    do_reset();
    s_rdy = 1'b1;
    m_op[3:2] = 2'b01;
    for (int c = 0; c < 4; c++) tick();
    m_op = 8'b00010001;
    collect(6);
    checks++;
    if (fp_q.size() != 6) begin
      errors++; $display("FAIL fp_count: got %0d accepts expected 6", fp_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (fp_q[k] != (k % 2) * 2) begin errors++; $display("FAIL fp_order[%0d]: got %0d expected %0d", k, fp_q[k], (k % 2) * 2); end
        checks++; if (fp_c[k] != (k / 2) * 4 + 1 + k % 2) begin errors++; $display("FAIL fp_cycle[%0d]: got %0d expected %0d", k, fp_c[k], (k / 2) * 4 + 1 + k % 2); end
      end
    end
    checks++; if (rr_q.size() == 0 || rr_q[0] != 2) begin errors++; $display("FAIL rr_after_m1: got %0d expected first idx 2", rr_q.size() == 0 ? -1 : rr_q[0]); end
    m_op = '0;
  endtask

  task automatic test_fifo_full;
    int cnt[MC];
    do_reset();
    m_op = 8'b01010101;
    for (int c = 0; c < 10; c++) tick();
    checks++; if (u_rr.count !== 2'd2) begin errors++; $display("FAIL full_count: got %0d expected 2", u_rr.count); end
    checks++; if (u_rr.pending !== 4'b0011) begin errors++; $display("FAIL full_pending: got %b expected 0011", u_rr.pending); end
    checks++; if (rr_sop !== 2'b01 || rr_saddr !== 30'd0) begin errors++; $display("FAIL full_head: got op %b addr %0d expected 01 0", rr_sop, rr_saddr); end
    checks++; if (rr_rdy !== 4'b0000) begin errors++; $display("FAIL full_rdy: got %b expected 0000", rr_rdy); end
    for (int i = 0; i < MC; i++) cnt[i] = 0;
    s_rdy = 1'b1;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < MC; i++)
        if (rr_rdy[i]) begin
          cnt[i]++;
          m_op[2*i +: 2] = 2'b00;
        end
      tick();
    end
    for (int i = 0; i < MC; i++) begin
      checks++; if (cnt[i] != 1) begin errors++; $display("FAIL full_done[%0d]: got %0d pulses expected 1", i, cnt[i]); end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    m_addr[AW-1:0] = 30'h20;
    s_data = 32'h11111111;
    s_rdy = 1'b1;
    m_op[1:0] = 2'b10;
    tick();
    checks++; if (rr_sop !== 2'b10) begin errors++; $display("FAIL bp_accept_sop: got %b expected 10", rr_sop); end
    tick();
    s_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (rr_rdy !== 4'b0000) begin errors++; $display("FAIL bp_stall_rdy[%0d]: got %b expected 0000", c, rr_rdy); end
      tick();
    end
    checks++; if (rr_rdy !== 4'b0000) begin errors++; $display("FAIL bp_last_rdy: got %b expected 0000", rr_rdy); end
    s_rdy = 1'b1;
    s_data = 32'hCAFEF00D;
    tick();
    checks++; if (rr_rdy !== 4'b0001) begin errors++; $display("FAIL bp_done_rdy: got %b expected 0001", rr_rdy); end
    checks++; if (rr_data[DW-1:0] !== 32'hCAFEF00D) begin errors++; $display("FAIL bp_data: got %h expected cafef00d", rr_data[DW-1:0]); end
    m_op = '0;
  endtask

  task automatic test_reset_mid;
    logic [MC-1:0] seen;
    do_reset();
    s_rdy = 1'b1;
    m_op = 8'b00010101;
    tick();
    tick();
    s_rdy = 1'b0;
    tick();
    checks++; if (u_rr.count !== 2'd2 || u_rr.inf_v !== 1'b1) begin errors++; $display("FAIL mid_state: got count %0d inflight %b expected 2 1", u_rr.count, u_rr.inf_v); end
    rst = 1'b1;
    m_op = '0;
    tick();
    rst = 1'b0;
    checks++; if (rr_sop !== 2'b00) begin errors++; $display("FAIL mid_sop: got %b expected 00", rr_sop); end
    s_rdy = 1'b1;
    seen = '0;
    for (int c = 0; c < 5; c++) begin
      seen |= rr_rdy;
      tick();
    end
    checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL mid_no_pulse: got %b expected 0000", seen); end
    s_data = 32'h5A5A5A5A;
    m_op[3:2] = 2'b10;
    tick();
    checks++; if (rr_sop !== 2'b10 || rr_saddr !== 30'd1) begin errors++; $display("FAIL mid_new_sop: got op %b addr %0d expected 10 1", rr_sop, rr_saddr); end
    tick();
    tick();
    checks++; if (rr_rdy !== 4'b0010) begin errors++; $display("FAIL mid_new_rdy: got %b expected 0010", rr_rdy); end
    checks++; if (rr_data[DW +: DW] !== 32'h5A5A5A5A) begin errors++; $display("FAIL mid_new_data: got %h expected 5a5a5a5a", rr_data[DW +: DW]); end
    m_op = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_fifo_full();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
